// File: rtl/uart_link_bridge.sv
// UART word FIFO feeding the board-to-board tsent/trecieve four-phase link.
// Define UART_LINK_BRIDGE_CRC_EN to append a running CRC word after every FRAME_LEN data words.
module uart_link_bridge #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 16,
  parameter int unsigned      FRAME_LEN = 4,
  parameter logic [WIDTH-1:0] CRC_POLY  = 8'h07
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  input  logic                     enable,
  input  logic                     clear_ovf,
  input  logic                     trecieve,
  output logic [WIDTH-1:0]         t_data,
  output logic                     tsent,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic [WIDTH-1:0]         crc,
  output logic                     frame_done
);

  localparam int unsigned addrW = $clog2(DEPTH);
  localparam int unsigned cntW  = addrW + 1;
  localparam int unsigned frmW  = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {stIdle, stSetup, stWaitAck, stWaitRel} linkState_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [addrW-1:0] wrPtr, rdPtr;
  logic [cntW-1:0]  countNext;
  logic [frmW-1:0]  frameCnt;
  logic             ackMeta, ackS;
  logic             crcPending, startXfer, pop, push, dropWord;
  linkState_t       state;

`ifdef UART_LINK_BRIDGE_CRC_EN
  logic [WIDTH-1:0] crcReg;
  logic             sendingCrc;

  // MSB-first serial CRC over one whole word, unrolled into a single cycle
  function automatic logic [WIDTH-1:0] crcStep(input logic [WIDTH-1:0] c,
                                               input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = c;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (r[WIDTH-1] ^ d[i]) r = (r << 1) ^ CRC_POLY;
      else                   r = r << 1;
    end
    return r;
  endfunction

  assign crcPending = (frameCnt == frmW'(FRAME_LEN));
  assign crc        = crcReg;
`else
  assign crcPending = 1'b0;
  assign crc        = '0;
`endif

  assign startXfer = (state == stIdle) && enable && (crcPending || !empty);
  assign pop       = startXfer && !crcPending;
  assign dropWord  = in_valid && full && !pop;
  assign push      = in_valid && !dropWord;
  assign countNext = fifo_count + cntW'(push) - cntW'(pop);

  // FIFO storage carries no reset; the pointers alone define its contents
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_count <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      fifo_count <= countNext;
      empty      <= (countNext == '0);
      full       <= (countNext == cntW'(DEPTH));
      if (dropWord)       overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  // The far-board acknowledge is asynchronous to clk
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ackMeta <= 1'b0;
      ackS    <= 1'b0;
    end else begin
      ackMeta <= trecieve;
      ackS    <= ackMeta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= stIdle;
      t_data     <= '0;
      tsent      <= 1'b0;
      frameCnt   <= '0;
      frame_done <= 1'b0;
`ifdef UART_LINK_BRIDGE_CRC_EN
      crcReg     <= '0;
      sendingCrc <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        stIdle: begin
          if (startXfer) begin
`ifdef UART_LINK_BRIDGE_CRC_EN
            if (crcPending) begin
              t_data     <= crcReg;
              sendingCrc <= 1'b1;
            end else begin
              t_data     <= mem[rdPtr];
              crcReg     <= crcStep(crcReg, mem[rdPtr]);
              sendingCrc <= 1'b0;
            end
`else
            t_data <= mem[rdPtr];
`endif
            state <= stSetup;
          end
        end
        // t_data has been stable for a full cycle before the request rises
        stSetup: begin
          tsent <= 1'b1;
          state <= stWaitAck;
        end
        stWaitAck: begin
          if (ackS) begin
            tsent <= 1'b0;
            state <= stWaitRel;
          end
        end
        stWaitRel: begin
          if (!ackS) begin
            state <= stIdle;
`ifdef UART_LINK_BRIDGE_CRC_EN
            if (sendingCrc) begin
              frame_done <= 1'b1;
              crcReg     <= '0;
              frameCnt   <= '0;
            end else begin
              frameCnt <= frameCnt + 1'b1;
            end
`else
            if (frameCnt == frmW'(FRAME_LEN - 1)) begin
              frame_done <= 1'b1;
              frameCnt   <= '0;
            end else begin
              frameCnt <= frameCnt + 1'b1;
            end
`endif
          end
        end
        default: state <= stIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_link_bridge.sv
// Directed bench for uart_link_bridge: reset, echo handshake, overflow, framing, stall and mid-handshake reset.
module tb_uart_link_bridge;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       enable;
  logic       clear_ovf;
  logic       trecieve;
  logic [7:0] t_data;
  logic       tsent;
  logic [4:0] fifo_count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic [7:0] crc;
  logic       frame_done;

  int         checks = 0;
  int         failures = 0;
  int         doneCnt = 0;
  logic [7:0] linkQ[$];
  logic [7:0] expQ[$];
  logic       tsentPrev = 1'b0;
  logic       autoAck = 1'b0;
  logic       manualAck = 1'b0;
  logic       echo = 1'b0;
  logic       drained;

  assign trecieve = autoAck ? echo : manualAck;

  uart_link_bridge dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .enable(enable), .clear_ovf(clear_ovf), .trecieve(trecieve),
    .t_data(t_data), .tsent(tsent), .fifo_count(fifo_count), .empty(empty),
    .full(full), .overflow(overflow), .crc(crc), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Far-board model: echoes tsent back shortly after each rising edge
  initial forever begin
    @(posedge clk);
    #2;
    echo = tsent;
  end

  // Link monitor: records the word present at every request rise
  initial forever begin
    @(negedge clk);
    if (tsent && !tsentPrev) linkQ.push_back(t_data);
    tsentPrev = tsent;
    if (frame_done) doneCnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    reset = 1'b0; in_valid = 1'b0; in_data = '0; enable = 1'b0;
    clear_ovf = 1'b0; autoAck = 1'b0; manualAck = 1'b0;
    tick(2);
    reset = 1'b1;
    linkQ.delete();
    doneCnt = 0;
    tick(1);
  endtask

  task automatic pushWord(input logic [7:0] d);
    in_data = d;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input int n, input string tag);
    drained = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (linkQ.size() == n && empty && !tsent && !trecieve) begin
        drained = 1'b1;
        break;
      end
      tick(1);
    end
    check(tag, 32'(drained), 32'd1);
    tick(6);
  endtask

`ifdef UART_LINK_BRIDGE_CRC_EN
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    repeat (8) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction
`endif

  initial begin
    // Reset values
    doReset();
    check("rst_tdata", 32'(t_data), 32'h0);
    check("rst_tsent", 32'(tsent), 32'h0);
    check("rst_count", 32'(fifo_count), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_full", 32'(full), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_crc", 32'(crc), 32'h0);
    check("rst_fdone", 32'(frame_done), 32'h0);

    // Single word with echoing acknowledger
    enable = 1'b1; autoAck = 1'b1;
    pushWord(8'hA5);
    check("t1_count_push", 32'(fifo_count), 32'd1);
    check("t1_empty_push", 32'(empty), 32'h0);
    tick(1);
    check("t1_tdata_load", 32'(t_data), 32'hA5);
    check("t1_tsent_setup", 32'(tsent), 32'h0);
    check("t1_count_pop", 32'(fifo_count), 32'd0);
    tick(1);
    check("t1_tsent_up", 32'(tsent), 32'h1);
    waitDrain(1, "t1_drain");
    check("t1_word", 32'(linkQ[0]), 32'hA5);

    // Overflow with link disabled, then drain in order
    doReset();
    autoAck = 1'b1;
    for (int i = 0; i < 17; i++) pushWord(8'(8'h20 + i));
    check("t2_full", 32'(full), 32'h1);
    check("t2_count", 32'(fifo_count), 32'd16);
    check("t2_ovf", 32'(overflow), 32'h1);
    clear_ovf = 1'b1;
    tick(1);
    clear_ovf = 1'b0;
    check("t2_ovf_clr", 32'(overflow), 32'h0);
    check("t2_full_hold", 32'(full), 32'h1);
    expQ.delete();
    for (int i = 0; i < 16; i++) expQ.push_back(8'(8'h20 + i));
`ifdef UART_LINK_BRIDGE_CRC_EN
    begin
      logic [7:0] c;
      logic [7:0] src[$];
      src = expQ;
      expQ.delete();
      c = '0;
      for (int i = 0; i < 16; i++) begin
        expQ.push_back(src[i]);
        c = crc8(c, src[i]);
        if (i % 4 == 3) begin
          expQ.push_back(c);
          c = '0;
        end
      end
    end
`endif
    enable = 1'b1;
    waitDrain(expQ.size(), "t2_drain");
    check("t2_nwords", 32'(linkQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < linkQ.size(); i++)
      check($sformatf("t2_word%0d", i), 32'(linkQ[i]), 32'(expQ[i]));
    check("t2_empty", 32'(empty), 32'h1);

    // One frame of 01..04
    doReset();
    autoAck = 1'b1; enable = 1'b1;
    for (int i = 1; i <= 4; i++) pushWord(8'(i));
`ifdef UART_LINK_BRIDGE_CRC_EN
    waitDrain(5, "t3_drain");
    check("t3_nwords", 32'(linkQ.size()), 32'd5);
    if (linkQ.size() == 5) check("t3_crcword", 32'(linkQ[4]), 32'hE3);
`else
    waitDrain(4, "t3_drain");
    check("t3_nwords", 32'(linkQ.size()), 32'd4);
`endif
    for (int i = 0; i < 4 && i < linkQ.size(); i++)
      check($sformatf("t3_word%0d", i), 32'(linkQ[i]), 32'(i + 1));
    check("t3_fdone", 32'(doneCnt), 32'd1);
    check("t3_crc0", 32'(crc), 32'h0);

    // Acknowledge held high stalls the link
    doReset();
    enable = 1'b1;
    pushWord(8'h55);
    pushWord(8'h66);
    for (int i = 0; i < 20 && !tsent; i++) tick(1);
    check("t5_req", 32'(tsent), 32'h1);
    check("t5_count1", 32'(fifo_count), 32'd1);
    manualAck = 1'b1;
    tick(2);
    check("t5_tsent_m1", 32'(tsent), 32'h1);
    tick(1);
    check("t5_tsent_m2", 32'(tsent), 32'h0);
    tick(5);
    check("t5_stall_tsent", 32'(tsent), 32'h0);
    check("t5_stall_count", 32'(fifo_count), 32'd1);
    check("t5_stall_tdata", 32'(t_data), 32'h55);
    manualAck = 1'b0;
    tick(3);
    check("t5_p2_count", 32'(fifo_count), 32'd1);
    tick(1);
    check("t5_p3_count", 32'(fifo_count), 32'd0);
    check("t5_p3_tdata", 32'(t_data), 32'h66);
    autoAck = 1'b1;
    waitDrain(2, "t5_drain");

    // Reset in the middle of a handshake
    doReset();
    for (int i = 0; i < 6; i++) pushWord(8'(8'h71 + i));
    enable = 1'b1;
    for (int i = 0; i < 20 && !tsent; i++) tick(1);
    check("t6_req", 32'(tsent), 32'h1);
    check("t6_queued", 32'(fifo_count), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_tsent", 32'(tsent), 32'h0);
    check("t6_async_count", 32'(fifo_count), 32'd0);
    check("t6_async_empty", 32'(empty), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    linkQ.delete();
    autoAck = 1'b1;
    tick(30);
    check("t6_no_stale", 32'(linkQ.size()), 32'd0);
    check("t6_tsent_idle", 32'(tsent), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_link_bridge.md
# uart_link_bridge

Parametrised successor to the single-byte COM→FIFO→parallel path. It accepts words from the UART receiver, buffers them in an internal circular FIFO, and drives them onto the board-to-board parallel link using the `tsent`/`trecieve` four-phase handshake. It optionally appends a running CRC word after every frame. It sits between the UART receiver and the inter-board connector and replaces the fixed 8-bit, CRC-on-display-only path.

## Interface

**Parameters**
- `WIDTH`, 8: data word and CRC width in bits.
- `DEPTH`, 16: FIFO depth in words; must be a power of 2, at least 2.
- `FRAME_LEN`, 4: data words per frame; must be at least 1.
- `CRC_POLY`, 8'h07: CRC polynomial, `WIDTH` bits, implicit top bit.

**Ports**
- `clk`, in, 1: single clock. Reset is asynchronous and active-low.
- `reset`, in, 1: active-low asynchronous reset.
- `in_data`, in, WIDTH: word from the UART receiver.
- `in_valid`, in, 1: one-cycle strobe; pushes `in_data`.
- `enable`, in, 1: permits a new link transfer to start.
- `clear_ovf`, in, 1: clears `overflow`.
- `trecieve`, in, 1: acknowledge from the far board; asynchronous.
- `t_data`, out, WIDTH: link data.
- `tsent`, out, 1: link request.
- `fifo_count`, out, $clog2(DEPTH)+1: words currently stored.
- `empty`, out, 1: asserted when `fifo_count` is 0.
- `full`, out, 1: asserted when `fifo_count` equals DEPTH.
- `overflow`, out, 1: sticky flag for a dropped push.
- `crc`, out, WIDTH: running CRC of the current frame.
- `frame_done`, out, 1: one-cycle pulse at frame completion.

## Operation

**Reset values**
- All outputs are 0, except `empty`, which is 1.
- Read and write pointers are 0 and the FSM is in IDLE.
- The frame counter and CRC are 0.
- Reset is asynchronous. Asserting it mid-handshake drops `tsent` immediately and discards FIFO contents.

**FIFO**
- Circular buffer with pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
- Push when `in_valid` is high and the FIFO is not full.
- Push while full with no pop in the same cycle: the word is dropped and `overflow` is set.
- Simultaneous push and pop while full: both happen and the count is unchanged.
- `clear_ovf` clears `overflow`. If a new overflow occurs in the same cycle, set wins.

**`trecieve` synchroniser**
- Two-flop synchroniser; the FSM sees only the output, `ack_s`.

**Link FSM**
- IDLE: if `enable` is high and (CRC is pending, or the FIFO is not empty):
  - If CRC is pending, load `t_data` with `crc`.
  - Otherwise pop the head into `t_data` and update `crc`.
  - Go to SETUP.
  - If `enable` is low, stay in IDLE.
- SETUP: `tsent` becomes 1; go to WAIT_ACK.
- WAIT_ACK: when `ack_s` is 1, `tsent` becomes 0; go to WAIT_REL.
- WAIT_REL: when `ack_s` is 0, the word is complete; go to IDLE.
- `enable` low only blocks starts; an in-flight handshake completes.
- `t_data` holds its value from the load until the next load.

**CRC and framing**
- CRC update on a data-word pop: process all WIDTH bits MSB-first in one cycle, starting from the current `crc`.
- The frame counter increments on each completed data word.

## Timing

- Push at edge N: `fifo_count` and `empty`/`full` update at N+1. The word can be popped at N+1 at the earliest.
- Load/pop in IDLE at edge k: `t_data` is valid after k, and `tsent` rises after edge k+1. This gives one full cycle of data setup before the request.
- Raw `trecieve` rising before edge m: `tsent` falls after edge m+2.
- Raw `trecieve` falling before edge p: the FSM is in IDLE after edge p+2. The next load can occur at p+3.
- `frame_done` is asserted during the cycle after the completing WAIT_REL→IDLE edge.
- `fifo_count` uses full-width unsigned arithmetic, never wraps, and is bounded in [0, DEPTH].

## Configuration

**`UART_LINK_BRIDGE_CRC_EN`: defined**
- When the frame counter reaches FRAME_LEN, CRC is pending. The next transfer sends `crc` as a link word.
- On completion of the CRC word:
  - `frame_done` pulses.
  - `crc` and the frame counter clear to 0.
- While CRC is pending, FIFO data is not popped.

**`UART_LINK_BRIDGE_CRC_EN`: not defined**
- No CRC logic is built and `crc` is tied to 0.
- `frame_done` pulses on completion of the FRAME_LEN-th data word, and the counter then clears.
- The link carries data words only.

## Test plan

- Reset, then push 8'hA5 with an immediate-echo acknowledger: `t_data`=8'hA5, `tsent` high two cycles after the push, `fifo_count` returns to 0.
- Push 17 words with `enable`=0 (DEPTH=16): `full`=1, `fifo_count`=16, `overflow`=1. Then `clear_ovf` → `overflow`=0. Set `enable`=1: the 16 words come out in order; the 17th was dropped.
- With CRC_EN, push 8'h01,02,03,04 (FRAME_LEN=4, poly 8'h07): link sequence is 01,02,03,04 followed by the CRC-8 of those four words, `frame_done` pulses once, and `crc` returns to 0.
- Without CRC_EN, push the same four words: exactly four link words, `frame_done` pulses after the fourth, `crc` stays 0.
- Hold `trecieve` high: `tsent` drops and the FSM stalls in WAIT_REL with no further pops. Drop `trecieve`: the next word starts 3 cycles later.
- Assert `reset` during WAIT_ACK with 5 words queued: `tsent`=0 immediately, `fifo_count`=0, `empty`=1. After release, no stale word is sent.
